// File: rtl/mips32_mem_arbiter_if.sv
// Bus bundle between the MIPS32 fetch/data requesters, the memory arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mips32_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Single-port arbiter sharing one unified memory between MIPS32 fetch and data ports.
// Define MIPS32_ARB_RR_EN for round-robin tie breaking; default is fixed data-over-fetch priority.
module mips32_mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    mips32_mem_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    state_e            state, state_n;
    logic [3:0]        lat_cnt, lat_cnt_n;
    owner_e            owner, owner_n;
    logic              cmd_we, cmd_we_n;

    logic              if_gnt_q, if_gnt_n;
    logic              dm_gnt_q, dm_gnt_n;
    logic              if_rvalid_q, if_rvalid_n;
    logic              dm_rvalid_q, dm_rvalid_n;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_n;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_n;

    logic              mem_en_q, mem_en_n;
    logic              mem_we_q, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;

    logic              any_req;
    logic              pick_dm;

    assign any_req = bus.if_req | bus.dm_req;

`ifdef MIPS32_ARB_RR_EN
    owner_e last_owner;

    // On a tie the port that was not granted most recently wins.
    always_comb begin
        pick_dm = bus.dm_req & (~bus.if_req | (last_owner == OWN_IF));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_IF;
        end else if (state == IDLE && any_req) begin
            last_owner <= owner_n;
        end
    end
`else
    always_comb begin
        pick_dm = bus.dm_req;
    end
`endif

    always_comb begin
        state_n     = state;
        lat_cnt_n   = lat_cnt;
        owner_n     = owner;
        cmd_we_n    = cmd_we;
        if_gnt_n    = 1'b0;
        dm_gnt_n    = 1'b0;
        if_rvalid_n = 1'b0;
        dm_rvalid_n = 1'b0;
        if_rdata_n  = if_rdata_q;
        dm_rdata_n  = dm_rdata_q;
        mem_en_n    = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_n   = ACCESS;
                    lat_cnt_n = LAT_INIT;
                    mem_en_n  = 1'b1;
                    if (pick_dm) begin
                        owner_n     = OWN_DM;
                        cmd_we_n    = bus.dm_we;
                        dm_gnt_n    = 1'b1;
                        mem_we_n    = bus.dm_we;
                        mem_addr_n  = bus.dm_addr;
                        mem_wdata_n = bus.dm_wdata;
                    end else begin
                        owner_n     = OWN_IF;
                        cmd_we_n    = 1'b0;
                        if_gnt_n    = 1'b1;
                        mem_addr_n  = bus.if_addr;
                        mem_wdata_n = '0;
                    end
                end
            end

            ACCESS: begin
                // Count runs to 0, not 1: mem_en is high in the first ACCESS cycle,
                // so read data lands MEM_LAT cycles later, one cycle after the count hits 1.
                if (lat_cnt == 4'd0) begin
                    state_n = RESP;
                    if (owner == OWN_DM) begin
                        dm_rvalid_n = 1'b1;
                        dm_rdata_n  = cmd_we ? '0 : bus.mem_rdata;
                    end else begin
                        if_rvalid_n = 1'b1;
                        if_rdata_n  = bus.mem_rdata;
                    end
                end else begin
                    lat_cnt_n = lat_cnt - 4'd1;
                end
            end

            RESP: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            owner       <= OWN_IF;
            cmd_we      <= 1'b0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state       <= state_n;
            lat_cnt     <= lat_cnt_n;
            owner       <= owner_n;
            cmd_we      <= cmd_we_n;
            if_gnt_q    <= if_gnt_n;
            dm_gnt_q    <= dm_gnt_n;
            if_rvalid_q <= if_rvalid_n;
            dm_rvalid_q <= dm_rvalid_n;
            if_rdata_q  <= if_rdata_n;
            dm_rdata_q  <= dm_rdata_n;
            mem_en_q    <= mem_en_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.dm_gnt    = dm_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and a behavioural memory. Honours MIPS32_ARB_RR_EN.
module tb_mips32_mem_arbiter;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips32_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mips32_mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural memory: reads return MEM_LAT cycles after mem_en, garbage otherwise.
    logic [31:0]       ram     [1024];
    logic [31:0]       ref_mem [1024];
    bit                mem_ready = 1'b0;
    int unsigned       rd_due    = 32'hffff_ffff;
    logic [ADDR_W-1:0] rd_addr   = '0;

    always begin
        @(posedge clk);
        cyc++;
        #1;
        bus.mem_rdata = (cyc == rd_due) ? ram[rd_addr] : $urandom;
    end

    // Transaction-level reference: one access per MEM_LAT+3 cycles, grant one cycle after sampling.
    bit                act       = 1'b0;
    bit                g_dm      = 1'b0;
    bit                g_we      = 1'b0;
    bit                last_dm   = 1'b0;
    int unsigned       g_cyc     = 0;
    int unsigned       smp_cyc   = 0;
    logic [ADDR_W-1:0] g_addr    = '0;
    logic [31:0]       g_wdata   = '0;
    logic [31:0]       g_rdata   = '0;
    logic [31:0]       e_if_rd   = '0;
    logic [31:0]       e_dm_rd   = '0;
    logic [ADDR_W-1:0] e_maddr   = '0;

    always @(negedge clk) begin
        int unsigned rv_cyc;
        bit          e_gnt;
        bit          e_rv;
        bit          win_dm;

        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) begin
                ram[i]     = $urandom;
                ref_mem[i] = ram[i];
            end
            ram[5]     = 32'h280a00c8;
            ref_mem[5] = 32'h280a00c8;
            mem_ready  = 1'b1;
        end

        rv_cyc = g_cyc + MEM_LAT + 1;
        e_gnt  = act && (cyc == g_cyc);
        e_rv   = act && (cyc == rv_cyc);
        if (e_gnt) e_maddr = g_addr;
        if (e_rv) begin
            if (g_dm) e_dm_rd = g_rdata;
            else      e_if_rd = g_rdata;
        end

        check("if_gnt",    bus.if_gnt,    e_gnt && !g_dm);
        check("dm_gnt",    bus.dm_gnt,    e_gnt && g_dm);
        check("mem_en",    bus.mem_en,    e_gnt);
        check("busy",      bus.busy,      act && cyc >= g_cyc && cyc <= rv_cyc);
        check("mem_addr",  bus.mem_addr,  e_maddr);
        check("if_rvalid", bus.if_rvalid, e_rv && !g_dm);
        check("dm_rvalid", bus.dm_rvalid, e_rv && g_dm);
        check("if_rdata",  bus.if_rdata,  e_if_rd);
        check("dm_rdata",  bus.dm_rdata,  e_dm_rd);
        if (e_gnt) check("mem_we", bus.mem_we, g_we);
        if (e_gnt && g_we) check("mem_wdata", bus.mem_wdata, g_wdata);

        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] = bus.mem_wdata;
            end else begin
                rd_due  = cyc + MEM_LAT;
                rd_addr = bus.mem_addr;
            end
        end

        if (rst) begin
            act     = 1'b0;
            last_dm = 1'b0;
            smp_cyc = cyc + 1;
            e_if_rd = '0;
            e_dm_rd = '0;
            e_maddr = '0;
        end else if (cyc == smp_cyc) begin
            if (bus.if_req || bus.dm_req) begin
`ifdef MIPS32_ARB_RR_EN
                win_dm = bus.dm_req && (!bus.if_req || !last_dm);
`else
                win_dm = bus.dm_req;
`endif
                last_dm = win_dm;
                act     = 1'b1;
                g_dm    = win_dm;
                g_cyc   = cyc + 1;
                g_we    = win_dm && bus.dm_we;
                g_addr  = win_dm ? bus.dm_addr : bus.if_addr;
                g_wdata = bus.dm_wdata;
                g_rdata = g_we ? 32'h0 : ref_mem[g_addr];
                if (g_we) ref_mem[g_addr] = g_wdata;
                smp_cyc = cyc + MEM_LAT + 3;
            end else begin
                smp_cyc = cyc + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check("idle_reached", bus.busy, 1'b0);
        step();
    endtask

    initial begin
        bit          if_g;
        bit          dm_g;
        int unsigned en_cnt;

        rst          = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Tie right after reset; the first tie goes to dm in either build.
        for (int k = 0; k <= 17; k++) begin
            if (k == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 10'd3;
                bus.dm_req  = 1'b1;
                bus.dm_we   = 1'b0;
                bus.dm_addr = 10'd4;
            end
`ifdef MIPS32_ARB_RR_EN
            if (k == 17) begin
                bus.if_req = 1'b0;
                bus.dm_req = 1'b0;
            end
            @(negedge clk);
            if (k == 1 || k == 11) check("tie_rr_dm_gnt", bus.dm_gnt, 1'b1);
            if (k == 6 || k == 16) check("tie_rr_if_gnt", bus.if_gnt, 1'b1);
`else
            if (k == 2) bus.dm_req = 1'b0;
            if (k == 7) bus.if_req = 1'b0;
            @(negedge clk);
            if (k == 1) check("tie_dm_gnt", bus.dm_gnt, 1'b1);
            if (k == 6) check("tie_if_gnt", bus.if_gnt, 1'b1);
`endif
            step();
        end
        wait_idle();

        // Fetch read from word 5.
        for (int k = 0; k <= 5; k++) begin
            if (k == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 10'd5;
            end
            if (k == 2) bus.if_req = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                check("fetch_gnt",     bus.if_gnt,   1'b1);
                check("fetch_mem_en",  bus.mem_en,   1'b1);
                check("fetch_mem_adr", bus.mem_addr, 10'd5);
                check("fetch_mem_we",  bus.mem_we,   1'b0);
            end
            if (k == 3) check("fetch_rv_early", bus.if_rvalid, 1'b0);
            if (k == 4) begin
                check("fetch_rvalid", bus.if_rvalid, 1'b1);
                check("fetch_rdata",  bus.if_rdata,  32'h280a00c8);
            end
            if (k == 5) check("fetch_busy_end", bus.busy, 1'b0);
            step();
        end
        wait_idle();

        // Store 24 to word 198, then load it back.
        for (int k = 0; k <= 10; k++) begin
            if (k == 0) begin
                bus.dm_req   = 1'b1;
                bus.dm_we    = 1'b1;
                bus.dm_addr  = 10'd198;
                bus.dm_wdata = 32'd24;
            end
            if (k == 2) bus.dm_req = 1'b0;
            if (k == 5) begin
                bus.dm_req   = 1'b1;
                bus.dm_we    = 1'b0;
                bus.dm_wdata = 32'hdead_beef;
            end
            if (k == 7) bus.dm_req = 1'b0;
            @(negedge clk);
            if (k == 4) begin
                check("store_rvalid", bus.dm_rvalid, 1'b1);
                check("store_rdata",  bus.dm_rdata,  32'd0);
            end
            if (k == 9) begin
                check("load_rvalid", bus.dm_rvalid, 1'b1);
                check("load_rdata",  bus.dm_rdata,  32'd24);
            end
            step();
        end
        wait_idle();

        // Reset in the middle of a fetch, then a fresh fetch.
        for (int k = 0; k <= 11; k++) begin
            if (k == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 10'd7;
            end
            if (k == 2) begin
                bus.if_req = 1'b0;
                rst        = 1'b1;
            end
            if (k == 3) rst = 1'b0;
            if (k == 6) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 10'd5;
            end
            if (k == 8) bus.if_req = 1'b0;
            @(negedge clk);
            if (k == 3) begin
                check("rst_if_gnt",    bus.if_gnt,    1'b0);
                check("rst_dm_gnt",    bus.dm_gnt,    1'b0);
                check("rst_if_rvalid", bus.if_rvalid, 1'b0);
                check("rst_dm_rvalid", bus.dm_rvalid, 1'b0);
                check("rst_if_rdata",  bus.if_rdata,  32'd0);
                check("rst_dm_rdata",  bus.dm_rdata,  32'd0);
                check("rst_mem_en",    bus.mem_en,    1'b0);
                check("rst_mem_we",    bus.mem_we,    1'b0);
                check("rst_mem_addr",  bus.mem_addr,  32'd0);
                check("rst_mem_wdata", bus.mem_wdata, 32'd0);
                check("rst_busy",      bus.busy,      1'b0);
            end
            if (k >= 4 && k <= 9) check("rst_no_rvalid", bus.if_rvalid, 1'b0);
            if (k == 10) begin
                check("post_rst_rvalid", bus.if_rvalid, 1'b1);
                check("post_rst_rdata",  bus.if_rdata,  32'h280a00c8);
            end
            step();
        end
        wait_idle();

        // Fetch request raised and withdrawn while a load is in flight.
        en_cnt = 0;
        for (int k = 0; k <= 8; k++) begin
            if (k == 0) begin
                bus.dm_req  = 1'b1;
                bus.dm_we   = 1'b0;
                bus.dm_addr = 10'd9;
            end
            if (k == 2) begin
                bus.dm_req  = 1'b0;
                bus.if_req  = 1'b1;
                bus.if_addr = 10'd11;
            end
            if (k == 4) bus.if_req = 1'b0;
            @(negedge clk);
            if (bus.mem_en) en_cnt++;
            check("wd_no_if_gnt", bus.if_gnt, 1'b0);
            step();
        end
        check("wd_mem_en_cnt", en_cnt, 32'd1);
        wait_idle();

        // Randomized traffic with withdrawals and occasional resets.
        if_g = 1'b0;
        dm_g = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (bus.if_req && if_g) begin
                bus.if_req = 1'b0;
            end else if (!bus.if_req && $urandom_range(0, 3) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 10'($urandom_range(0, 15));
            end else if (bus.if_req && $urandom_range(0, 31) == 0) begin
                bus.if_req = 1'b0;
            end
            if (bus.dm_req && dm_g) begin
                bus.dm_req = 1'b0;
            end else if (!bus.dm_req && $urandom_range(0, 3) == 0) begin
                bus.dm_req   = 1'b1;
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_addr  = 10'($urandom_range(0, 15));
                bus.dm_wdata = $urandom;
            end else if (bus.dm_req && $urandom_range(0, 31) == 0) begin
                bus.dm_req = 1'b0;
            end
            @(negedge clk);
            if_g = bus.if_gnt;
            dm_g = bus.dm_gnt;
            step();
        end
        rst = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
